// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcodes, write-back selects and the
// MEM/WB payload type.
package cpu_pkg;

    localparam int unsigned DW  = 32;
    localparam int unsigned RW  = 5;
    localparam int unsigned OPW = 6;

    localparam logic [OPW-1:0] OP_LB  = 6'b100000;
    localparam logic [OPW-1:0] OP_LH  = 6'b100001;
    localparam logic [OPW-1:0] OP_LW  = 6'b100011;
    localparam logic [OPW-1:0] OP_LBU = 6'b100100;
    localparam logic [OPW-1:0] OP_LHU = 6'b100101;
    localparam logic [OPW-1:0] OP_SB  = 6'b101000;
    localparam logic [OPW-1:0] OP_SW  = 6'b101011;

    localparam logic [1:0] WBSEL_ALU = 2'b00;
    localparam logic [1:0] WBSEL_MEM = 2'b01;
    localparam logic [1:0] WBSEL_PC8 = 2'b10;

    typedef struct packed {
        logic          valid;
        logic          we;
        logic          excp;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } wb_t;

    // A half-word load at an odd byte, or a word load off a word boundary.
    function automatic logic is_misaligned(input logic [OPW-1:0] op, input logic [1:0] off);
        return (((op == OP_LH) || (op == OP_LHU)) && off[0]) ||
               ((op == OP_LW) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Memory-stage bundle, hazard controls and the registered write-back port.
interface mem_wb_stage_if;
    import cpu_pkg::*;

    logic                stall;
    logic                flush;
    logic                in_valid;
    logic [OPW-1:0]      in_op;
    logic [DW-1:0]       in_addr;
    logic [DW-1:0]       in_mem_word;
    logic [DW-1:0]       in_alu;
    logic [DW-1:0]       in_pc8;
    logic [RW-1:0]       in_rd;
    logic                in_regwrite;
    logic [1:0]          in_wbsel;

    logic                wb_valid;
    logic                wb_we;
    logic [RW-1:0]       wb_rd;
    logic [DW-1:0]       wb_data;
    logic                wb_excp;

    modport master (
        output stall, flush, in_valid, in_op, in_addr, in_mem_word, in_alu,
               in_pc8, in_rd, in_regwrite, in_wbsel,
        input  wb_valid, wb_we, wb_rd, wb_data, wb_excp
    );

    modport slave (
        input  stall, flush, in_valid, in_op, in_addr, in_mem_word, in_alu,
               in_pc8, in_rd, in_regwrite, in_wbsel,
        output wb_valid, wb_we, wb_rd, wb_data, wb_excp
    );

endinterface

// File: rtl/load_ext.sv
// Sub-word load alignment and extension: picks the lane selected by the byte
// offset and sign- or zero-extends it to a full word.
module load_ext
    import cpu_pkg::*;
(
    input  logic [OPW-1:0] op,
    input  logic [1:0]     offset,
    input  logic [31:0]    word,
    output logic [31:0]    value_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = word[7:0];
        case (offset)
            2'd1:    byte_c = word[15:8];
            2'd2:    byte_c = word[23:16];
            2'd3:    byte_c = word[31:24];
            default: byte_c = word[7:0];
        endcase
        half_c = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        value_c = word;
        case (op)
            OP_LB:   value_c = {{24{byte_c[7]}}, byte_c};
            OP_LBU:  value_c = {24'h000000, byte_c};
            OP_LH:   value_c = {{16{half_c[15]}}, half_c};
            OP_LHU:  value_c = {16'h0000, half_c};
            default: value_c = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction and write-back select.
// Optional misaligned-load trap: define MEM_WB_MISALIGN_TRAP_EN.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DW = cpu_pkg::DW,
    parameter int unsigned RW = cpu_pkg::RW
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_wb_stage_if.slave    bus
);

    wb_t           wb_q;
    wb_t           wb_d_c;
    logic [31:0]   ld_c;
    logic [DW-1:0] wdata_c;
    logic [RW-1:0] rd_c;
    logic          excp_c;
    logic          unused_c;

    assign unused_c = ^bus.in_addr[DW-1:2];
    assign rd_c     = bus.in_rd;

    load_ext u_load_ext (
        .op      (bus.in_op),
        .offset  (bus.in_addr[1:0]),
        .word    (bus.in_mem_word),
        .value_c (ld_c)
    );

`ifdef MEM_WB_MISALIGN_TRAP_EN
    assign excp_c = bus.in_valid & is_misaligned(bus.in_op, bus.in_addr[1:0]);
`else
    assign excp_c = 1'b0;
`endif

    // Write-back source; the reserved encoding falls back to the ALU result.
    always_comb begin
        wdata_c = bus.in_alu;
        case (bus.in_wbsel)
            WBSEL_MEM: wdata_c = ld_c;
            WBSEL_PC8: wdata_c = bus.in_pc8;
            default:   wdata_c = bus.in_alu;
        endcase
    end

    // flush beats stall; a stall simply holds the current slot.
    always_comb begin
        wb_d_c = wb_q;
        if (bus.flush) begin
            wb_d_c = '0;
        end else if (!bus.stall) begin
            wb_d_c.valid = bus.in_valid;
            wb_d_c.we    = bus.in_valid & bus.in_regwrite & (rd_c != '0) & ~excp_c;
            wb_d_c.excp  = excp_c;
            wb_d_c.rd    = rd_c;
            wb_d_c.data  = wdata_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d_c;
        end
    end

    assign bus.wb_valid = wb_q.valid;
    assign bus.wb_we    = wb_q.we;
    assign bus.wb_excp  = wb_q.excp;
    assign bus.wb_rd    = wb_q.rd;
    assign bus.wb_data  = wb_q.data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: behavioural model checked every cycle plus directed
// literal expectations. Honours MEM_WB_MISALIGN_TRAP_EN.
module tb_mem_wb_stage;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model: extracted load value from the word, shifted down to the lane.
    function automatic logic [31:0] m_ext(input logic [5:0] op, input logic [1:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * a));
        h = 16'(w >> (16 * a[1]));
        if (op == OP_LB)  return 32'($signed(b));
        if (op == OP_LBU) return {24'd0, b};
        if (op == OP_LH)  return 32'($signed(h));
        if (op == OP_LHU) return {16'd0, h};
        return w;
    endfunction

    function automatic logic m_mis(input logic v, input logic [5:0] op, input logic [1:0] a);
`ifdef MEM_WB_MISALIGN_TRAP_EN
        if (!v) return 1'b0;
        if ((op == OP_LH || op == OP_LHU) && a % 2 == 1) return 1'b1;
        if (op == OP_LW && a != 0) return 1'b1;
        return 1'b0;
`else
        return 1'b0 & v & op[0] & a[0];
`endif
    endfunction

    function automatic logic [31:0] m_data(input logic [1:0] sel, input logic [31:0] ld,
                                           input logic [31:0] alu, input logic [31:0] pc8);
        if (sel == 2'b01) return ld;
        if (sel == 2'b10) return pc8;
        return alu;
    endfunction

    logic        e_valid, e_we, e_excp;
    logic [4:0]  e_rd;
    logic [31:0] e_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid <= 1'b0; e_we <= 1'b0; e_excp <= 1'b0; e_rd <= 5'd0; e_data <= 32'd0;
        end else if (bus.flush) begin
            e_valid <= 1'b0; e_we <= 1'b0; e_excp <= 1'b0; e_rd <= 5'd0; e_data <= 32'd0;
        end else if (!bus.stall) begin
            e_valid <= bus.in_valid;
            e_we    <= bus.in_valid && bus.in_regwrite && bus.in_rd != 0 &&
                       !m_mis(bus.in_valid, bus.in_op, bus.in_addr[1:0]);
            e_excp  <= m_mis(bus.in_valid, bus.in_op, bus.in_addr[1:0]);
            e_rd    <= bus.in_rd;
            e_data  <= m_data(bus.in_wbsel, m_ext(bus.in_op, bus.in_addr[1:0], bus.in_mem_word),
                              bus.in_alu, bus.in_pc8);
        end
    end

    // Every cycle, away from the active edge.
    always @(negedge clk) begin
        check("model_valid", 32'(bus.wb_valid), 32'(e_valid));
        check("model_we",    32'(bus.wb_we),    32'(e_we));
        check("model_excp",  32'(bus.wb_excp),  32'(e_excp));
        check("model_rd",    32'(bus.wb_rd),    32'(e_rd));
        check("model_data",  bus.wb_data,       e_data);
    end

    task automatic apply(input logic v, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] word, input logic [31:0] alu, input logic [31:0] pc8,
                         input logic [4:0] rd, input logic rw, input logic [1:0] sel);
        bus.in_valid    = v;
        bus.in_op       = op;
        bus.in_addr     = addr;
        bus.in_mem_word = word;
        bus.in_alu      = alu;
        bus.in_pc8      = pc8;
        bus.in_rd       = rd;
        bus.in_regwrite = rw;
        bus.in_wbsel    = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_valid"}, 32'(bus.wb_valid), 32'd0);
        check({name, "_we"},    32'(bus.wb_we),    32'd0);
        check({name, "_excp"},  32'(bus.wb_excp),  32'd0);
        check({name, "_rd"},    32'(bus.wb_rd),    32'd0);
        check({name, "_data"},  bus.wb_data,       32'd0);
    endtask

    initial begin
        logic [31:0] lb_exp [4];
        lb_exp[0] = 32'h00000001; lb_exp[1] = 32'h0000007F;
        lb_exp[2] = 32'hFFFFFFFF; lb_exp[3] = 32'hFFFFFF80;

        rst_n = 1'b0;
        bus.stall = 1'b0; bus.flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_addr = '0; bus.in_mem_word = '0;
        bus.in_alu = '0; bus.in_pc8 = '0; bus.in_rd = '0; bus.in_regwrite = 1'b0;
        bus.in_wbsel = '0;
        #12;
        check_zero("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            apply(1'b1, OP_LB, 32'h00000100 + 32'(i), 32'h80FF7F01, 32'h0, 32'h0, 5'd3, 1'b1, WBSEL_MEM);
            check($sformatf("lb_a%0d", i), bus.wb_data, lb_exp[i]);
            check($sformatf("lb_we_a%0d", i), 32'(bus.wb_we), 32'd1);
        end
        apply(1'b1, OP_LBU, 32'h00000103, 32'h80FF7F01, 32'h0, 32'h0, 5'd3, 1'b1, WBSEL_MEM);
        check("lbu_a3", bus.wb_data, 32'h00000080);

        apply(1'b1, OP_LH, 32'h00000200, 32'h8001FFFE, 32'h0, 32'h0, 5'd4, 1'b1, WBSEL_MEM);
        check("lh_a0", bus.wb_data, 32'hFFFFFFFE);
        apply(1'b1, OP_LHU, 32'h00000202, 32'h8001FFFE, 32'h0, 32'h0, 5'd4, 1'b1, WBSEL_MEM);
        check("lhu_a2", bus.wb_data, 32'h00008001);
        apply(1'b1, OP_LW, 32'h00000200, 32'h8001FFFE, 32'h0, 32'h0, 5'd4, 1'b1, WBSEL_MEM);
        check("lw", bus.wb_data, 32'h8001FFFE);
        check("lw_rd", 32'(bus.wb_rd), 32'd4);

        apply(1'b1, OP_LW, 32'h00000200, 32'h12345678, 32'h0, 32'h0, 5'd0, 1'b1, WBSEL_MEM);
        check("r0_we", 32'(bus.wb_we), 32'd0);
        check("r0_valid", 32'(bus.wb_valid), 32'd1);
        apply(1'b1, 6'b000011, 32'h0, 32'h0, 32'h0, 32'h00003008, 5'd31, 1'b1, WBSEL_PC8);
        check("link_data", bus.wb_data, 32'h00003008);
        check("link_we", 32'(bus.wb_we), 32'd1);
        apply(1'b1, 6'b000000, 32'h0, 32'hFFFFFFFF, 32'h12345678, 32'h1, 5'd5, 1'b1, 2'b11);
        check("wbsel_rsv", bus.wb_data, 32'h12345678);
        apply(1'b0, OP_LW, 32'h0, 32'h0, 32'h1, 32'h0, 5'd6, 1'b1, WBSEL_ALU);
        check("bubble_valid", 32'(bus.wb_valid), 32'd0);
        check("bubble_we", 32'(bus.wb_we), 32'd0);

        apply(1'b1, 6'b000000, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 5'd7, 1'b1, WBSEL_ALU);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, OP_LB, 32'h1, 32'hA5A5A5A5, 32'h11111111 * 32'(i + 1), 32'h0, 5'd9, 1'b1, WBSEL_ALU);
            check($sformatf("stall%0d_data", i), bus.wb_data, 32'hDEADBEEF);
            check($sformatf("stall%0d_rd", i), 32'(bus.wb_rd), 32'd7);
            check($sformatf("stall%0d_we", i), 32'(bus.wb_we), 32'd1);
        end
        bus.flush = 1'b1;
        apply(1'b1, 6'b000000, 32'h0, 32'h0, 32'h22222222, 32'h0, 5'd9, 1'b1, WBSEL_ALU);
        check("flush_valid", 32'(bus.wb_valid), 32'd0);
        check("flush_we", 32'(bus.wb_we), 32'd0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        apply(1'b1, 6'b000000, 32'h0, 32'h0, 32'hAAAA5555, 32'h0, 5'd9, 1'b1, WBSEL_ALU);
        check("pre_rst_data", bus.wb_data, 32'hAAAA5555);
        bus.stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_stall");
        @(posedge clk); #2;
        rst_n = 1'b1;
        bus.stall = 1'b0;
        apply(1'b1, 6'b000000, 32'h0, 32'h0, 32'h00000055, 32'h0, 5'd4, 1'b1, WBSEL_ALU);
        check("post_rst_data", bus.wb_data, 32'h00000055);
        check("post_rst_valid", 32'(bus.wb_valid), 32'd1);

        apply(1'b1, OP_LW, 32'h00000102, 32'h11223344, 32'h0, 32'h0, 5'd8, 1'b1, WBSEL_MEM);
        check("mis_lw_data", bus.wb_data, 32'h11223344);
`ifdef MEM_WB_MISALIGN_TRAP_EN
        check("mis_lw_excp", 32'(bus.wb_excp), 32'd1);
        check("mis_lw_we", 32'(bus.wb_we), 32'd0);
`else
        check("mis_lw_excp", 32'(bus.wb_excp), 32'd0);
        check("mis_lw_we", 32'(bus.wb_we), 32'd1);
`endif
        apply(1'b1, OP_LH, 32'h00000101, 32'h11228344, 32'h0, 32'h0, 5'd8, 1'b1, WBSEL_MEM);
        check("mis_lh_data", bus.wb_data, 32'hFFFF8344);
        apply(1'b0, OP_LW, 32'h00000102, 32'h0, 32'h0, 32'h0, 5'd8, 1'b1, WBSEL_MEM);
        check("mis_bubble_excp", 32'(bus.wb_excp), 32'd0);
        apply(1'b0, 6'b000000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, WBSEL_ALU);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register for the five-stage CPU; sits directly downstream of the 4 KiB data memory.
- Each cycle it captures the memory-stage bundle: op, address, word read from data memory, ALU result, PC+8, destination register and control.
- It aligns and extends sub-word loads (lb/lbu/lh/lhu/lw) and presents one registered write-back port to the register file.
- It supports stall (hold) and flush (bubble) from hazard control.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all stage registers.
- flush  in  1  load a bubble.
- in_valid  in  1  memory-stage slot holds a real instruction.
- in_op  in  6  primary opcode of the instruction.
- in_addr  in  32  effective address; only [1:0] are used.
- in_mem_word  in  32  word read from data memory at in_addr[11:2].
- in_alu  in  32  ALU result.
- in_pc8  in  32  PC+8 for link instructions.
- in_rd  in  5  destination register index.
- in_regwrite  in  1  instruction writes the register file.
- in_wbsel  in  2  write-back source: 00 ALU, 01 load, 10 PC+8, 11 reserved (treated as ALU).
- wb_valid  out  1  write-back slot valid.
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  register-file write index.
- wb_data  out  32  register-file write data.
- wb_excp  out  1  misaligned-load exception (optional feature; constant 0 when the feature is off).

Behaviour:
- Reset: rst_n low asynchronously clears wb_valid, wb_we, wb_rd, wb_data and wb_excp to 0. This applies even mid-stall. The first edge after release samples normally.
- Latency: one cycle. Inputs sampled at rising edge N appear on the outputs after edge N.
- Priority at each rising edge: flush > stall > normal load.
- flush: clears wb_valid, wb_we and wb_excp. wb_rd and wb_data are don't-care; they are cleared to 0 for determinism.
- stall without flush: all outputs hold their previous value.
- Normal load: wb_valid = in_valid; wb_rd = in_rd; wb_we = in_valid & in_regwrite & (in_rd != 0) & ~excp. Register 0 is never written.
- Load extraction uses the word in_mem_word and offset a = in_addr[1:0]:
  - lb 100000: byte lane a (bits 8a+7:8a), sign-extended.
  - lbu 100100: byte lane a, zero-extended.
  - lh 100001: half-word selected by a[1] (lane 0 = [15:0], lane 1 = [31:16]), sign-extended. a[0] ignored when the feature is off.
  - lhu 100101: same lane selection as lh, zero-extended.
  - lw 100011 and any other op: full word; a ignored.
- wb_data mux: ALU result, extended load value, or in_pc8, chosen by in_wbsel.
- Bubble input (in_valid=0): wb_valid=0 and wb_we=0 regardless of in_regwrite.

Optional Feature:
- Macro: MEM_WB_MISALIGN_TRAP_EN.
- Defined: the stage computes misalignment = in_valid & ((lh|lhu) & a[0] | lw & (a != 0)).
  - It registers this into wb_excp.
  - It forces wb_we=0 for that slot.
  - wb_data still carries the extracted value.
- Undefined: wb_excp tied to 0 and no alignment checking is done.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SW;
  - WBSEL_ALU, WBSEL_MEM, WBSEL_PC8;
  - the DW/RW defaults.
- One combinational sub-module, load_ext (op, offset, word -> 32-bit extended value), reused by any future forwarding path.

Test Plan:
- Reset: assert rst_n=0 mid-stream, including while stall=1 -> all outputs 0 immediately, without waiting for a clock edge.
- Byte loads: in_mem_word=0x80FF7F01, lb at a=0..3 -> wb_data 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; lbu a=3 -> 0x00000080.
- Half-word loads: in_mem_word=0x8001FFFE, lh a=0 -> 0xFFFFFFFE; lhu a=2 -> 0x00008001; lw -> 0x8001FFFE.
- Register 0 and link: in_rd=0 with in_regwrite=1 -> wb_we=0 and wb_valid=1; in_wbsel=10, in_pc8=0x00003008 -> wb_data=0x00003008.
- Stall/flush: stall=1 for 3 cycles -> outputs frozen; stall=1 and flush=1 together -> wb_valid=0, wb_we=0 on the next edge.
- Feature on: lw at addr 0x00000102 -> wb_excp=1, wb_we=0. Feature off, same stimulus -> wb_excp=0, wb_we=1.
